// File: rtl/znmi_pkg.sv
// Shared constants and helpers for the multi-source NMI controller.
package znmi_pkg;

  localparam logic [15:0] ENTRY_ADDR_DEF = 16'h0066;

  localparam int SRC_SPI = 0;
  localparam int SRC_BTN = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/znmi_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module znmi_prio_enc
  import znmi_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int IW   = (NSRC > 1) ? clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/znmi_ctrl.sv
// Multi-source NMI controller: request latching, NMI pulse generation and
// tracking of the NMI service window, including ROM-deferred entry.
module znmi_ctrl
  import znmi_pkg::*;
#(
  parameter int          NSRC       = 2,
  parameter int          PULSE_LEN  = 7,
  parameter int          CLR_RFSH   = 2,
  parameter logic [15:0] ENTRY_ADDR = ENTRY_ADDR_DEF,
  parameter int          SYNC_INT   = 1,
  localparam int         SW         = (NSRC > 1) ? clog2(NSRC) : 1,
  localparam int         PW         = clog2(PULSE_LEN + 1)
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            zpos,
  input  logic            zneg,
  input  logic            int_start,
  input  logic [NSRC-1:0] set_nmi,
  input  logic [NSRC-1:0] nmi_mask,
  input  logic            clr_nmi,
  input  logic            rfsh_n,
  input  logic            m1_n,
  input  logic            mreq_n,
  input  logic            csrom,
  input  logic [15:0]     a,
  output logic            in_nmi,
  output logic            gen_nmi,
  output logic [SW-1:0]   nmi_src,
  output logic [NSRC-1:0] nmi_pending
);

  logic m1_r, mreq_r, rfsh_s0, rfsh_s1, was_m1_d;
  logic last_m1_rom, last_m1_entry;
  logic was_m1, rfsh_fall;

  logic [NSRC-1:0] set_prev, req_edge, win_mask;
  logic [SW-1:0]   win_idx;
  logic            win_valid, int_ok, fire, deferred_entry, clr_done;
  logic            in_nmi_2, pending_clr;
  logic [PW-1:0]   pulse_cnt;
  logic [3:0]      clr_cnt;

  assign was_m1    = ~(m1_r | mreq_r);
  assign rfsh_fall = rfsh_s1 & ~rfsh_s0;

  // Bus strobes are idle-high, so their shadows reset high.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m1_r          <= 1'b1;
      mreq_r        <= 1'b1;
      rfsh_s0       <= 1'b1;
      rfsh_s1       <= 1'b1;
      was_m1_d      <= 1'b0;
      last_m1_rom   <= 1'b0;
      last_m1_entry <= 1'b0;
    end else begin
      if (zpos) begin
        m1_r    <= m1_n;
        rfsh_s0 <= rfsh_n;
      end
      if (zneg) mreq_r <= mreq_n;
      rfsh_s1  <= rfsh_s0;
      was_m1_d <= was_m1;
      if (was_m1 & ~was_m1_d) begin
        last_m1_rom   <= csrom & (a[15:14] == 2'b00);
        last_m1_entry <= (a == ENTRY_ADDR);
      end
    end
  end

  znmi_prio_enc #(.NSRC(NSRC), .IW(SW)) u_prio (
    .req   (nmi_pending & ~nmi_mask),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    req_edge       = set_prev & ~set_nmi;
    int_ok         = (SYNC_INT != 0) ? int_start : 1'b1;
    fire           = win_valid & ~in_nmi & ~in_nmi_2 & ~gen_nmi & int_ok;
    deferred_entry = in_nmi_2 & rfsh_fall & last_m1_entry;
    // A fresh clr_nmi restarts the countdown instead of closing the window.
    clr_done       = pending_clr & (clr_cnt == 4'd0) & ~clr_nmi;
    win_mask       = '0;
    if (fire) win_mask[win_idx] = 1'b1;
  end

  assign gen_nmi = (pulse_cnt != '0);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      set_prev    <= '0;
      nmi_pending <= '0;
      nmi_src     <= '0;
      pulse_cnt   <= '0;
      in_nmi      <= 1'b0;
      in_nmi_2    <= 1'b0;
      clr_cnt     <= 4'd0;
      pending_clr <= 1'b0;
    end else begin
      set_prev    <= set_nmi;
      // A new edge outranks the service clear of the same source.
      nmi_pending <= (nmi_pending & ~win_mask) | req_edge;
      if (fire) nmi_src <= win_idx;

      if (fire) pulse_cnt <= PW'(PULSE_LEN);
      else if (zpos && pulse_cnt != '0) pulse_cnt <= pulse_cnt - PW'(1);

      if (fire & last_m1_rom) in_nmi_2 <= 1'b1;
      else if (deferred_entry) in_nmi_2 <= 1'b0;

      if (clr_done) in_nmi <= 1'b0;
      else if ((fire & ~last_m1_rom) | deferred_entry) in_nmi <= 1'b1;

      if (clr_nmi) begin
        clr_cnt     <= 4'(CLR_RFSH);
        pending_clr <= 1'b1;
      end else begin
        if (rfsh_fall && clr_cnt != 4'd0) clr_cnt <= clr_cnt - 4'd1;
        if (clr_done) pending_clr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_znmi_ctrl.sv
// Bench for znmi_ctrl: two instances (INT-synchronous and immediate) checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_znmi_ctrl;

  localparam int PULSE = 7;
  localparam int CLRN  = 2;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zpos = 1'b0, zneg = 1'b0, int_start = 1'b0, clr_nmi = 1'b0;
  logic [1:0]  set_nmi = 2'b11, nmi_mask = 2'b00;
  logic        rfsh_n = 1'b1, m1_n = 1'b1, mreq_n = 1'b1, csrom = 1'b0;
  logic [15:0] a = 16'h0000;

  logic [1:0]  d_in, d_gen;
  logic        d_src [2];
  logic [1:0]  d_pend [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  // ---------------- clock / reset / Z80 strobes ----------------
  always #5 fclk = ~fclk;

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge fclk);
      zpos  = (phase == 0);
      zneg  = (phase == 2);
      phase = (phase + 1) % 4;
    end
  end

  znmi_ctrl #(.NSRC(2), .PULSE_LEN(PULSE), .CLR_RFSH(CLRN), .ENTRY_ADDR(16'h0066), .SYNC_INT(1)) u_sync (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .int_start(int_start),
    .set_nmi(set_nmi), .nmi_mask(nmi_mask), .clr_nmi(clr_nmi), .rfsh_n(rfsh_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .csrom(csrom), .a(a),
    .in_nmi(d_in[0]), .gen_nmi(d_gen[0]), .nmi_src(d_src[0]), .nmi_pending(d_pend[0])
  );

  znmi_ctrl #(.NSRC(2), .PULSE_LEN(PULSE), .CLR_RFSH(CLRN), .ENTRY_ADDR(16'h0066), .SYNC_INT(0)) u_async (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .int_start(int_start),
    .set_nmi(set_nmi), .nmi_mask(nmi_mask), .clr_nmi(clr_nmi), .rfsh_n(rfsh_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .csrom(csrom), .a(a),
    .in_nmi(d_in[1]), .gen_nmi(d_gen[1]), .nmi_src(d_src[1]), .nmi_pending(d_pend[1])
  );

  // ---------------- behavioural model ----------------
  // Bus view shared by both instances; controller state per instance (0: INT-synced).
  bit m1_seen = 1, mreq_seen = 1, rf_now = 1, rf_prev = 1, fetch_prev = 0;
  bit rom_fetch = 0, entry_fetch = 0;
  bit [1:0] lvl_prev = 2'b00;
  bit [1:0] m_pend [2] = '{2'b00, 2'b00};
  bit       m_src [2]  = '{0, 0};
  int       m_ticks [2] = '{0, 0};
  int       m_clrc [2]  = '{0, 0};
  bit       m_win [2]   = '{0, 0};
  bit       m_defer [2] = '{0, 0};
  bit       m_closing [2] = '{0, 0};

  always @(posedge fclk or negedge rst_n) begin
    bit fetching, refresh_fell, go, enter_late, close_now;
    bit [1:0] falls;
    int winner;
    if (!rst_n) begin
      m1_seen = 1; mreq_seen = 1; rf_now = 1; rf_prev = 1; fetch_prev = 0;
      rom_fetch = 0; entry_fetch = 0; lvl_prev = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 2'b00; m_src[k] = 0; m_ticks[k] = 0; m_clrc[k] = 0;
        m_win[k] = 0; m_defer[k] = 0; m_closing[k] = 0;
      end
    end else begin
      fetching     = !(m1_seen || mreq_seen);
      refresh_fell = rf_prev && !rf_now;
      falls        = lvl_prev & ~set_nmi;
      for (int k = 0; k < 2; k++) begin
        winner = -1;
        for (int i = 1; i >= 0; i--)
          if (m_pend[k][i] && !nmi_mask[i]) winner = i;
        go = (winner >= 0) && !m_win[k] && !m_defer[k] && (m_ticks[k] == 0) &&
             (k == 1 || int_start);
        enter_late = m_defer[k] && refresh_fell && entry_fetch;
        close_now  = m_closing[k] && (m_clrc[k] == 0) && !clr_nmi;
        if (go) begin
          m_pend[k][winner] = 1'b0;
          m_src[k]   = (winner == 1);
          m_ticks[k] = PULSE;
        end else if (zpos && m_ticks[k] > 0) begin
          m_ticks[k]--;
        end
        m_pend[k] = m_pend[k] | falls;
        if (go && rom_fetch) m_defer[k] = 1;
        else if (enter_late) m_defer[k] = 0;
        if (close_now) m_win[k] = 0;
        else if ((go && !rom_fetch) || enter_late) m_win[k] = 1;
        if (clr_nmi) begin
          m_clrc[k] = CLRN; m_closing[k] = 1;
        end else begin
          if (refresh_fell && m_clrc[k] > 0) m_clrc[k]--;
          if (close_now) m_closing[k] = 0;
        end
      end
      rf_prev = rf_now;
      if (zpos) begin m1_seen = m1_n; rf_now = rfsh_n; end
      if (zneg) mreq_seen = mreq_n;
      if (fetching && !fetch_prev) begin
        rom_fetch   = csrom && (a[15:14] == 2'b00);
        entry_fetch = (a == 16'h0066);
      end
      fetch_prev = fetching;
      lvl_prev   = set_nmi;
    end
    if (fclk)
      exp_q.push_back({m_win[1], m_ticks[1] > 0, m_src[1], m_pend[1],
                       m_win[0], m_ticks[0] > 0, m_src[0], m_pend[0]});
  end

  // ---------------- per-cycle scoreboard ----------------
  initial begin
    logic [9:0] e;
    logic [4:0] got, want;
    forever begin
      @(posedge fclk);
      #2;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL model_queue: got empty queue, required one entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 2; k++) begin
          got  = {d_in[k], d_gen[k], d_src[k], d_pend[k]};
          want = (k == 0) ? e[4:0] : e[9:5];
          if (got !== want) begin
            n_bad++;
            $display("FAIL cycle_inst%0d t=%0t {in,gen,src,pend}: got %b required %b", k, $time, got, want);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge fclk);
  endtask

  task automatic req(input logic [1:0] bits);
    @(negedge fclk); set_nmi = ~bits;
    cyc(2); set_nmi = 2'b11;
  endtask

  task automatic int_pulse();
    @(negedge fclk); int_start = 1'b1;
    @(negedge fclk); int_start = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge fclk); clr_nmi = 1'b1;
    @(negedge fclk); clr_nmi = 1'b0;
  endtask

  task automatic m1_fetch(input logic [15:0] addr, input logic rom);
    @(negedge fclk); a = addr; csrom = rom; m1_n = 1'b0; mreq_n = 1'b0;
    cyc(8); m1_n = 1'b1; mreq_n = 1'b1; csrom = 1'b0;
    cyc(2);
  endtask

  task automatic rfsh_cycle();
    @(negedge fclk); rfsh_n = 1'b0;
    cyc(8); rfsh_n = 1'b1;
    cyc(8);
  endtask

  // Counts the zpos ticks during which the synced instance drives gen_nmi.
  task automatic measure_pulse(input string name);
    int ticks;
    ticks = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge fclk);
      if (zpos && d_gen[0]) ticks++;
      #2;
      if (!d_gen[0]) break;
    end
    check(name, ticks, PULSE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cyc(3);
    check("reset_in_nmi", d_in[0], 0);
    check("reset_gen", d_gen[0], 0);
    check("reset_src", d_src[0], 0);
    check("reset_pend", d_pend[0], 0);
    @(negedge fclk); rst_n = 1'b1;
    cyc(3);

    // Request from RAM-resident code, fire on INT.
    m1_fetch(16'h8000, 1'b0);
    req(2'b01);
    check("t1_latched", d_pend[0], 2'b01);
    check("t1_idle_gen", d_gen[0], 0);
    int_pulse();
    check("t1_in_nmi", d_in[0], 1);
    check("t1_gen", d_gen[0], 1);
    check("t1_src", d_src[0], 0);
    check("t1_pend", d_pend[0], 2'b00);
    measure_pulse("t1_pulse_ticks");

    // Close after two refresh falls; a second write restarts the count.
    clr_pulse();
    rfsh_cycle();
    check("t3_after_1fall", d_in[0], 1);
    rfsh_cycle();
    check("t3_after_2fall", d_in[0], 0);
    req(2'b01);
    int_pulse();
    check("t3b_reopen", d_in[0], 1);
    clr_pulse();
    rfsh_cycle();
    clr_pulse();
    rfsh_cycle();
    check("t3b_reload_1fall", d_in[0], 1);
    rfsh_cycle();
    check("t3b_reload_2fall", d_in[0], 0);

    // Simultaneous requests serviced in priority order.
    req(2'b11);
    int_pulse();
    check("t4_first_src", d_src[0], 0);
    check("t4_first_pend", d_pend[0], 2'b10);
    clr_pulse(); rfsh_cycle(); rfsh_cycle();
    check("t4_closed", d_in[0], 0);
    int_pulse();
    check("t4_second_src", d_src[0], 1);
    check("t4_second_pend", d_pend[0], 2'b00);
    check("t4_second_in", d_in[0], 1);
    clr_pulse(); rfsh_cycle(); rfsh_cycle();

    // Masked request stays latched until unmasked.
    nmi_mask = 2'b01;
    req(2'b01);
    int_pulse();
    check("t5_masked_in", d_in[0], 0);
    check("t5_masked_gen", d_gen[0], 0);
    check("t5_masked_pend", d_pend[0], 2'b01);
    @(negedge fclk); nmi_mask = 2'b00;
    int_pulse();
    check("t5_unmasked_in", d_in[0], 1);
    check("t5_unmasked_src", d_src[0], 0);
    check("t5_unmasked_pend", d_pend[0], 2'b00);
    clr_pulse(); rfsh_cycle(); rfsh_cycle();

    // NMI while executing ROM: window opens only after the 0066 fetch.
    m1_fetch(16'h1234, 1'b1);
    rfsh_cycle();
    req(2'b01);
    int_pulse();
    check("t2_gen", d_gen[0], 1);
    check("t2_deferred", d_in[0], 0);
    measure_pulse("t2_pulse_ticks");
    rfsh_cycle();
    check("t2_other_rfsh", d_in[0], 0);
    m1_fetch(16'h0066, 1'b1);
    check("t2_entry_fetch", d_in[0], 0);
    rfsh_cycle();
    check("t2_entry_rfsh", d_in[0], 1);
    clr_pulse(); rfsh_cycle(); rfsh_cycle();
    check("t2_closed", d_in[0], 0);
    m1_fetch(16'h8000, 1'b0);

    // Asynchronous reset mid-pulse inside the window.
    req(2'b10);
    int_pulse();
    cyc(3);
    check("t6_pre_in", d_in[0], 1);
    check("t6_pre_gen", d_gen[0], 1);
    check("t6_pre_src", d_src[0], 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_in", d_in, 2'b00);
    check("t6_rst_gen", d_gen, 2'b00);
    check("t6_rst_src", {d_src[1], d_src[0]}, 2'b00);
    check("t6_rst_pend", {d_pend[1], d_pend[0]}, 4'b0000);
    @(negedge fclk); rst_n = 1'b1;
    cyc(3);

    // Immediate-fire instance: edge, then fire on the next cycle.
    @(negedge fclk); set_nmi = 2'b01;
    @(posedge fclk); #2;
    check("t6_async_latched", d_pend[1], 2'b10);
    check("t6_async_not_yet", d_gen[1], 0);
    @(posedge fclk); #2;
    check("t6_async_gen", d_gen[1], 1);
    check("t6_async_in", d_in[1], 1);
    check("t6_async_src", d_src[1], 1);
    check("t6_async_pend", d_pend[1], 2'b00);
    check("t6_sync_waits", d_gen[0], 0);
    check("t6_sync_pend", d_pend[0], 2'b10);
    @(negedge fclk); set_nmi = 2'b11;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/znmi_ctrl.md
Name: znmi_ctrl

Overview:
Parametrised multi-source NMI controller for the Z80 core.
- Latches edge-triggered requests from NSRC sources (slavespi, buttons, debug), with per-source mask and fixed priority.
- Fires a fixed-width NMI pulse, either aligned to INT start or immediately.
- Tracks the NMI-service window (in_nmi), including the delayed entry when the NMI lands while executing ROM.
- Closes the window after a clear write plus a configurable number of refresh cycles.

Parameters:
NSRC, 2, number of request sources (1..8)
PULSE_LEN, 7, gen_nmi width in zpos ticks (1..255)
CLR_RFSH, 2, refresh cycles after clr_nmi before in_nmi drops (1..15)
ENTRY_ADDR, 16'h0066, M1 address that completes ROM-deferred entry
SYNC_INT, 1, 1: fire only on int_start; 0: fire on any fclk cycle

Ports:
fclk  in  1  master clock
rst_n  in  1  asynchronous active-low reset
zpos  in  1  Z80 clock rising-edge strobe
zneg  in  1  Z80 clock falling-edge strobe
int_start  in  1  one-cycle strobe at INT start
set_nmi  in  NSRC  request levels; falling edge = request
nmi_mask  in  NSRC  1 = source blocked from firing (still latched)
clr_nmi  in  1  one-cycle strobe from port write (#xxBE)
rfsh_n  in  1  Z80 RFSH_n
m1_n  in  1  Z80 M1_n
mreq_n  in  1  Z80 MREQ_n
csrom  in  1  ROM currently mapped/selected
a  in  16  Z80 address bus
in_nmi  out  1  NMI service window: RAM page #FF mapped at 0000-3FFF
gen_nmi  out  1  1 = drive NMI_n low
nmi_src  out  max(1,clog2(NSRC))  index of source that caused the last NMI
nmi_pending  out  NSRC  latched, not yet serviced requests

Behaviour:
- Reset (async, rst_n=0): in_nmi=0, gen_nmi=0, nmi_src=0, nmi_pending=0; internal in_nmi_2, pulse and clear counters = 0.
- Bus sampling:
  - m1_n registered on zpos; mreq_n registered on zneg.
  - rfsh_n registered on zpos into stage0, then copied to stage1 every fclk.
  - was_m1 = ~(m1_r | mreq_r).
  - On the was_m1 rising edge, capture:
    - last_m1_rom = csrom & (a[15:14]==0)
    - last_m1_entry = (a==ENTRY_ADDR)
  - rfsh_fall = stage1 & ~stage0.
- Request edge: set_nmi delayed one fclk; req_edge[i] = prev[i] & ~set_nmi[i].
  - Edge sets nmi_pending[i].
  - Edge on the same cycle as that source's service clear: set wins.
- Fire condition:
  - fire = |(nmi_pending & ~nmi_mask) & ~in_nmi & ~in_nmi_2 & ~gen_nmi & (SYNC_INT ? int_start : 1).
  - Winner = lowest unmasked pending index.
  - On fire:
    - nmi_src <= winner
    - clear only the winner's pending bit
    - load pulse counter with PULSE_LEN
    - if ~last_m1_rom, in_nmi <= 1 on the next edge
    - else in_nmi_2 <= 1
- Pulse: gen_nmi = (pulse_cnt != 0), registered.
  - Counter decrements on zpos while nonzero.
  - gen_nmi is high exactly PULSE_LEN zpos ticks, starting the fclk after fire.
  - No retrigger while high.
- Deferred entry:
  - When in_nmi_2 & rfsh_fall & last_m1_entry: in_nmi_2 <= 0 and in_nmi <= 1 in the same cycle.
  - ROM fetch at ENTRY_ADDR therefore completes from ROM before the RAM switch.
- Clear:
  - clr_nmi loads clr_cnt = CLR_RFSH and sets pending_clr; reloads if already counting.
  - clr_cnt decrements on rfsh_fall while nonzero.
  - When pending_clr & clr_cnt==0: in_nmi <= 0 and pending_clr <= 0.
  - Clearing has priority over any in_nmi set in the same cycle.
  - clr_nmi with in_nmi=0 runs harmlessly.
- Masking: a masked pending request stays latched and fires later when unmasked.
- Multiple pendings: serviced one per window, in priority order.
- Widths: pulse counter is clog2(PULSE_LEN+1) bits; clear counter is 4 bits; all unsigned, no wrap (saturate at 0).

Decomposition:
- Shared package znmi_pkg: ENTRY_ADDR default, source index constants (SRC_SPI=0, SRC_BTN=1), clog2 function.
- One sub-module: znmi_prio_enc (NSRC-wide lowest-index priority encoder with valid output).

Test Plan:
1. set_nmi[0] 1->0, last M1 at 8000, SYNC_INT=1, next int_start -> gen_nmi high for 7 zpos ticks; in_nmi=1 the cycle after fire; nmi_src=0; nmi_pending=00.
2. Request while last M1 at ROM 1234 -> in_nmi stays 0 through the 0066 M1; goes 1 at the rfsh fall after the 0066 fetch; gen_nmi pulse unchanged.
3. in_nmi=1, clr_nmi pulse, CLR_RFSH=2 -> in_nmi drops at the 2nd rfsh_fall; a second clr_nmi after the 1st rfsh_fall delays the drop to 2 more falls.
4. Sources 0 and 1 edge on the same cycle -> first NMI nmi_src=0 with pending=10; after clear, the next int_start fires with nmi_src=1.
5. nmi_mask=01, edge on source 0 -> no fire, pending=01; mask cleared -> fires at the next int_start.
6. rst_n asserted mid-pulse and in_nmi=1 -> all outputs 0 immediately (async); SYNC_INT=0 variant fires the cycle after the edge without int_start.
